// File: rtl/uc_booth_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uc_booth_pkg : shared state, opcode and width definitions         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package uc_booth_pkg;

   localparam int N_BITS_DEF = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ARITH = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // Booth pair {Q0, q-1}: 01 adds M, 10 subtracts M, equal bits do nothing.
   function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
      case ({q0, qm1})
         2'b01:   return OP_ADD;
         2'b10:   return OP_SUB;
         default: return OP_NOP;
      endcase
   endfunction

endpackage : uc_booth_pkg
`default_nettype wire

// File: rtl/uc_contador.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uc_contador : iteration counter, sync clear, enable, terminal cnt |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module uc_contador #(
   parameter int CW     = 2,
   parameter int TC_VAL = 2
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [CW-1:0] o_cnt,
   output logic          o_tc
);

   localparam logic [CW-1:0] c_TC = CW'(TC_VAL);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_inc)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == c_TC);

endmodule : uc_contador
`default_nettype wire

// File: rtl/uc_booth.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uc_booth : radix-2 Booth multiplier control unit                  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module uc_booth
   import uc_booth_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int CW     = $clog2(N_BITS + 1)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          inicio,
   input  logic          q0,
   input  logic          q_menos1,
   output logic          Carga_A,
   output logic          Carga_QM,
   output logic          Desplaza_AQ,
   output logic          Reset_A,
   output logic          Resta,
   output logic          ocupado,
   output logic          fin,
   output logic [CW-1:0] iter
);

   state_t    r_state;
   booth_op_t w_op;
   logic      w_last;
   logic      w_clr;
   logic      w_inc;

   assign w_clr = (r_state == LOAD);
   assign w_inc = (r_state == SHIFT);

   // Terminal count fires while the last shift is in progress (iter == N_BITS-1).
   uc_contador #(
      .CW     (CW),
      .TC_VAL (N_BITS - 1)
   ) u_contador (
      .clk   (clk),
      .rst_n (reset),
      .i_clr (w_clr),
      .i_inc (w_inc),
      .o_cnt (iter),
      .o_tc  (w_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (inicio) r_state <= LOAD;
            LOAD:    r_state <= ARITH;
            ARITH:   r_state <= SHIFT;
            SHIFT:   r_state <= w_last ? DONE : ARITH;
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_op = booth_decode(q0, q_menos1);

   // Pure decode of state so an async reset clears the controls immediately.
   always_comb begin
      Carga_A     = 1'b0;
      Carga_QM    = 1'b0;
      Desplaza_AQ = 1'b0;
      Reset_A     = 1'b1;
      Resta       = 1'b0;
      ocupado     = 1'b0;
      fin         = 1'b0;
      case (r_state)
         LOAD: begin
            Carga_QM = 1'b1;
            Reset_A  = 1'b0;
            ocupado  = 1'b1;
         end
         ARITH: begin
            Carga_A = (w_op != OP_NOP);
            Resta   = (w_op == OP_SUB);
            ocupado = 1'b1;
         end
         SHIFT: begin
            Desplaza_AQ = 1'b1;
            ocupado     = 1'b1;
         end
         DONE: begin
            fin     = 1'b1;
            ocupado = 1'b1;
         end
         default: ;
      endcase
   end

endmodule : uc_booth
`default_nettype wire
